// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: FSM states, frame
// constants and the three-sample majority helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte handshake between the UART receiver (master) and its consumer,
// normally uart_wishbone_bridge (slave).
interface uart_receiver_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen so the output comes out of reset matching the line's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with majority-voted mid-bit sampling, a one-deep holding
// register on a valid/ready handshake, and frame-error / overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic uart_rxd,
  uart_receiver_if.master rx_bus,
  output logic frame_err_o,
  output logic overrun_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  logic                 rxd_s;
  logic [1:0]           rxd_hist;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 sample_pt;
  logic                 vote;
  logic                 byte_done;
  logic                 stop_fail;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d    (uart_rxd),
    .q    (rxd_s)
  );

  // rxd_hist holds the two previous rxd_s values, so at counter=0 the vote
  // covers the samples taken at counter values 2, 1 and 0.
  assign sample_pt = (cnt_q == '0);
  assign vote      = majority3(rxd_hist[1], rxd_hist[0], rxd_s);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rxd_hist  <= 2'b11;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rxd_hist  <= {rxd_hist[0], rxd_s};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_fail = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end

      ST_START: begin
        if (!sample_pt) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d   = ST_DATA;
          cnt_d     = CNT_FULL;
          bit_idx_d = '0;
        end
      end

      ST_DATA: begin
        if (!sample_pt) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (!sample_pt) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (vote) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_fail = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A completed byte is dropped only when the held byte is neither empty nor
  // being consumed this cycle; otherwise it replaces whatever was held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_fail;
      overrun_o   <= byte_done && valid_q && !rx_bus.ready_i;
      if (byte_done) begin
        if (!valid_q || rx_bus.ready_i) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && rx_bus.ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_bus.data_o  = data_q;
  assign rx_bus.valid_o = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised and directed bench for uart_receiver: a frame-level model
// predicts each completion from the frame start time and checks every cycle.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;
  // Two synchroniser flops, one detect cycle, half a bit, then nine full bits.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         ferr;
  } ev_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic uart_rxd = 1'b1;
  logic frame_err_o;
  logic overrun_o;

  uart_receiver_if rx_bus();

  uart_receiver #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .uart_rxd   (uart_rxd),
    .rx_bus     (rx_bus),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  ev_t        evq[$];
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;

  int         n_valid, n_ferr, n_ovr, n_hs, first_valid;
  logic [7:0] last_data;

  bit rand_ready = 1'b0;
  bit ready_fixed = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Ready driver: either a fixed level or a fresh random bit each cycle.
  initial begin
    rx_bus.ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      rx_bus.ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Compare, capture, then advance the model to the state after the next edge.
  initial begin
    forever begin
      @(negedge clk_i);
      check("valid_o", 32'(rx_bus.valid_o), 32'(m_valid));
      check("frame_err_o", 32'(frame_err_o), 32'(m_ferr));
      check("overrun_o", 32'(overrun_o), 32'(m_ovr));
      if (m_valid) check("data_o", 32'(rx_bus.data_o), 32'(m_data));

      if (rx_bus.valid_o === 1'b1) begin
        n_valid++;
        last_data = rx_bus.data_o;
        if (first_valid < 0) first_valid = cyc;
        if (rx_bus.ready_i === 1'b1) n_hs++;
      end
      if (frame_err_o === 1'b1) n_ferr++;
      if (overrun_o === 1'b1) n_ovr++;

      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rst_i) begin
        m_data  = 8'h00;
        m_valid = 1'b0;
        evq.delete();
      end else begin
        bit was_valid;
        was_valid = m_valid;
        if (m_valid && rx_bus.ready_i) m_valid = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc + 1) begin
          ev_t ev;
          ev = evq.pop_front();
          if (ev.ferr) begin
            m_ferr = 1'b1;
          end else if (was_valid && !rx_bus.ready_i) begin
            m_ovr = 1'b1;
          end else begin
            m_data  = ev.data;
            m_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic clear_capture();
    n_valid = 0;
    n_ferr = 0;
    n_ovr = 0;
    n_hs = 0;
    first_valid = -1;
    last_data = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drives one start/8 data/stop frame; rst_at >= 0 aborts with a reset there.
  task automatic applyStimulus(input logic [7:0] b, input bit stop, input bit spike,
                               input int rst_at, output int start_cyc);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge clk_i);
    #1;
    start_cyc = cyc;
    evq.push_back('{cyc + LAT, b, !stop});
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        if (k != 0 || j != 0) begin
          @(posedge clk_i);
          #1;
        end
        if (k * CPB + j == rst_at) begin
          rst_i = 1'b1;
          uart_rxd = 1'b1;
          idle_cycles(4);
          rst_i = 1'b0;
          return;
        end
        uart_rxd = bits[k] ^ (spike && j == 7);
      end
    end
  endtask

  task automatic checkOutput(input string name, input int got_valid, input logic [7:0] want);
    check({name, "_count"}, 32'(n_valid), 32'(got_valid));
    check({name, "_data"}, 32'(last_data), 32'(want));
  endtask

  initial begin
    int s;
    clear_capture();
    idle_cycles(3);
    check("reset_valid", 32'(rx_bus.valid_o), 32'd0);
    check("reset_data", 32'(rx_bus.data_o), 32'h00);
    check("reset_ferr", 32'(frame_err_o), 32'd0);
    check("reset_ovr", 32'(overrun_o), 32'd0);
    rst_i = 1'b0;
    idle_cycles(10);

    $display("[TB] frame 0xA5, ready high");
    clear_capture();
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, s);
    idle_cycles(5);
    check("a5_latency", 32'(first_valid - s), 32'd155);
    checkOutput("a5", 1, 8'hA5);
    check("a5_errs", 32'(n_ferr + n_ovr), 32'd0);

    $display("[TB] 4-cycle glitch then 0x3C");
    clear_capture();
    @(posedge clk_i);
    #1;
    uart_rxd = 1'b0;
    idle_cycles(4);
    uart_rxd = 1'b1;
    idle_cycles(30);
    check("glitch_valid", 32'(n_valid), 32'd0);
    check("glitch_ferr", 32'(n_ferr), 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
    applyStimulus(8'h3C, 1'b1, 1'b0, -1, s);
    idle_cycles(5);
    checkOutput("3c", 1, 8'h3C);

    $display("[TB] 0x55 with stop low, break, then 0x0F");
    clear_capture();
    applyStimulus(8'h55, 1'b0, 1'b0, -1, s);
    idle_cycles(40);
    uart_rxd = 1'b1;
    idle_cycles(10);
    check("break_ferr", 32'(n_ferr), 32'd1);
    check("break_valid", 32'(n_valid), 32'd0);
    clear_capture();
    applyStimulus(8'h0F, 1'b1, 1'b0, -1, s);
    idle_cycles(5);
    checkOutput("0f", 1, 8'h0F);

    $display("[TB] overrun: 0x11 then 0x22 with ready low");
    ready_fixed = 1'b0;
    idle_cycles(2);
    clear_capture();
    applyStimulus(8'h11, 1'b1, 1'b0, -1, s);
    idle_cycles(3);
    applyStimulus(8'h22, 1'b1, 1'b0, -1, s);
    idle_cycles(5);
    check("ovr_held_data", 32'(rx_bus.data_o), 32'h11);
    check("ovr_held_valid", 32'(rx_bus.valid_o), 32'd1);
    check("ovr_pulses", 32'(n_ovr), 32'd1);
    ready_fixed = 1'b1;
    idle_cycles(4);
    check("ovr_handshakes", 32'(n_hs), 32'd1);
    check("ovr_after_hs", 32'(rx_bus.valid_o), 32'd0);

    $display("[TB] 0x80 with spikes at sample points");
    clear_capture();
    applyStimulus(8'h80, 1'b1, 1'b1, -1, s);
    idle_cycles(5);
    checkOutput("80", 1, 8'h80);

    $display("[TB] reset mid-frame of 0xFF, then 0x42");
    clear_capture();
    applyStimulus(8'hFF, 1'b1, 1'b0, 5 * CPB, s);
    idle_cycles(200);
    check("rst_valid", 32'(n_valid), 32'd0);
    check("rst_data", 32'(rx_bus.data_o), 32'h00);
    applyStimulus(8'h42, 1'b1, 1'b0, -1, s);
    idle_cycles(5);
    checkOutput("42", 1, 8'h42);

    $display("[TB] randomised frames with random ready");
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(8'($urandom), 1'b1, ($urandom_range(0, 3) == 0), -1, s);
      idle_cycles($urandom_range(0, 20));
    end
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    idle_cycles(20);
    check("queue_drained", 32'(evq.size()), 32'd0);
    check("final_valid", 32'(rx_bus.valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
